// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out transmitter. A word accepted on the load
//   valid/ready interface is shifted out one bit per accepted beat on the
//   serial valid/ready interface. The frame is N beats, ending with ser_last.
//
//   Optional feature (macro PISO_PARITY_EN): an even-parity bit of the loaded
//   word is sent as one extra beat after the data. The frame then becomes
//   N+1 beats, and ser_last marks only the parity beat.
//
// Parameters:
//   N          data word width in bits (>= 2)
//   LSB_FIRST  1 = bit 0 is sent first, 0 = bit N-1 is sent first
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   load_data   parallel word to transmit
//   load_valid  load_data is valid
//   load_ready  block can accept a word (IDLE)
//   ser_out     current serial bit (0 when ser_valid is low)
//   ser_valid   ser_out is valid (SHIFT)
//   ser_last    current beat is the final beat of the frame
//   ser_ready   receiver accepts the current beat
//   busy        a frame is in progress
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] load_data,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ser_last,
    input  logic         ser_ready,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);

`ifdef PISO_PARITY_EN
    localparam int BEATS = N + 1;
`else
    localparam int BEATS = N;
`endif

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   shift_reg;
    logic [N-1:0]   shift_next;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           data_bit;
    logic [N-1:0]   shifted;

`ifdef PISO_PARITY_EN
    logic           parity_reg;
    logic           parity_next;
`endif

    // The output end of the shift register depends on the bit order; the
    // register always moves toward that end and fills with zeros.
    assign data_bit = LSB_FIRST ? shift_reg[0] : shift_reg[N-1];
    assign shifted  = LSB_FIRST ? {1'b0, shift_reg[N-1:1]}
                                : {shift_reg[N-2:0], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            count      <= '0;
`ifdef PISO_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            count      <= count_next;
`ifdef PISO_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Outputs are purely state-based, so a stalled beat (ser_ready low)
    // presents the same bit, last flag and valid until it is accepted.
    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        count_next  = count;
`ifdef PISO_PARITY_EN
        parity_next = parity_reg;
`endif
        load_ready  = 1'b0;
        ser_valid   = 1'b0;
        ser_last    = 1'b0;
        ser_out     = 1'b0;
        busy        = 1'b0;

        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shift_next  = load_data;
                    count_next  = '0;
`ifdef PISO_PARITY_EN
                    parity_next = ^load_data;
`endif
                    state_next  = SHIFT;
                end
            end

            SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_last  = (count == LAST_BEAT);
`ifdef PISO_PARITY_EN
                // Beat index N is the trailing parity beat.
                ser_out   = (count == CW'(N)) ? parity_reg : data_bit;
`else
                ser_out   = data_bit;
`endif
                if (ser_ready) begin
                    shift_next = shifted;
                    count_next = count + 1'b1;
                    if (count == LAST_BEAT) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Drives two serializers (LSB-first and MSB-first) with shared inputs and
//   compares every cycle against a frame-level reference model: a word, a
//   beat index and the expected bit taken straight from the word. Accepted
//   beats are also reassembled into a word and compared at each frame end.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int N = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] load_data = '0;
    logic         load_valid = 1'b0;
    logic         ser_ready = 1'b0;

    logic load_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l;
    logic load_ready_m, ser_out_m, ser_valid_m, ser_last_m, busy_m;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit           m_busy = 1'b0;
    logic [N-1:0] m_word = '0;
    int           m_beat = 0;
    logic [N-1:0] rec_l = '0;
    logic [N-1:0] rec_m = '0;
    logic         prev_out_l = 1'b0;
    logic         prev_out_m = 1'b0;

    piso_serializer #(.N(N), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .ser_last(ser_last_l), .ser_ready(ser_ready), .busy(busy_l)
    );

    piso_serializer #(.N(N), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
        .ser_last(ser_last_m), .ser_ready(ser_ready), .busy(busy_m)
    );

    always #5 clk = ~clk;

    // Expected serial bit for beat index 'beat' of word 'w'.
    function automatic logic exp_bit(input logic [N-1:0] w, input int beat, input bit lsb);
        if (beat >= N) return logic'($countones(w) % 2);
        return lsb ? w[beat] : w[N-1-beat];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic el, em;
        el = m_busy ? exp_bit(m_word, m_beat, 1'b1) : 1'b0;
        em = m_busy ? exp_bit(m_word, m_beat, 1'b0) : 1'b0;
        check("lsb.load_ready", 32'(load_ready_l), 32'(!m_busy));
        check("lsb.busy",       32'(busy_l),       32'(m_busy));
        check("lsb.ser_valid",  32'(ser_valid_l),  32'(m_busy));
        check("lsb.ser_last",   32'(ser_last_l),   32'(m_busy && m_beat == FRAME-1));
        check("lsb.ser_out",    32'(ser_out_l),    32'(el));
        check("msb.load_ready", 32'(load_ready_m), 32'(!m_busy));
        check("msb.busy",       32'(busy_m),       32'(m_busy));
        check("msb.ser_valid",  32'(ser_valid_m),  32'(m_busy));
        check("msb.ser_last",   32'(ser_last_m),   32'(m_busy && m_beat == FRAME-1));
        check("msb.ser_out",    32'(ser_out_m),    32'(em));
        prev_out_l = ser_out_l;
        prev_out_m = ser_out_m;
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, then
    // sample the DUT outputs 1 time unit after the edge.
    task automatic step(input logic lv, input logic [N-1:0] d, input logic sr);
        load_valid = lv;
        load_data  = d;
        ser_ready  = sr;
        @(posedge clk);
        if (!reset) begin
            if (!m_busy) begin
                if (lv) begin
                    m_busy = 1'b1;
                    m_word = d;
                    m_beat = 0;
                    rec_l  = '0;
                    rec_m  = '0;
                end
            end else if (sr) begin
                if (m_beat < N) begin
                    rec_l[m_beat]     = prev_out_l;
                    rec_m[N-1-m_beat] = prev_out_m;
                end else begin
                    check("parity_beat", 32'(prev_out_l), 32'($countones(m_word) % 2));
                end
                if (m_beat == FRAME-1) begin
                    check("frame_lsb", 32'(rec_l), 32'(m_word));
                    check("frame_msb", 32'(rec_m), 32'(m_word));
                    m_busy = 1'b0;
                end else begin
                    m_beat++;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        m_busy = 1'b0;
        check_outputs();
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        reset = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] d, input int idle_after);
        step(1'b1, d, 1'b1);
        for (int i = 0; i < FRAME + idle_after; i++) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        // Power-on reset state
        #2;
        m_busy = 1'b0;
        check_outputs();
        step(1'b0, '0, 1'b0);
        reset = 1'b0;
        step(1'b0, '0, 1'b0);

        // A5 with ser_ready high (MSB instance sees 01-style ordering too)
        send(8'hA5, 1);
        // 01: MSB-first ends with the 1 on the last beat
        send(8'h01, 1);

        // F0 with alternating backpressure
        step(1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < 2*FRAME + 2; i++) step(1'b0, '0, 1'(i % 2));

        // Load held during SHIFT must wait for IDLE
        step(1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < FRAME + 2; i++) step(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < FRAME + 1; i++) step(1'b0, '0, 1'b1);

        // Reset mid-frame after 3 beats, then a fresh frame
        step(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        async_reset();
        send(8'h81, 1);

        // Parity-relevant words (plain frames when parity is disabled)
        send(8'h07, 1);
        send(8'h03, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, N'($urandom), $urandom_range(0, 2) != 0);
        for (int i = 0; i < 2*FRAME + 4; i++) step(1'b0, '0, 1'b1);
        check("drained_idle", 32'(busy_l | busy_m), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
